// File: rtl/edge_delay_pkg.sv
// Shared definitions for the multi-channel edge delay block: delay-mode
// encodings, per-channel state type and the edge selection helper.
package edge_delay_pkg;

    localparam logic [1:0] DLY_RISE = 2'd0;
    localparam logic [1:0] DLY_FALL = 2'd1;
    localparam logic [1:0] DLY_BOTH = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } ch_state_e;

    // Reserved mode 3 behaves like DLY_BOTH.
    function automatic logic edge_is_delayed(input logic [1:0] mode, input logic target_level);
        case (mode)
            DLY_RISE: return target_level;
            DLY_FALL: return !target_level;
            DLY_BOTH: return 1'b1;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/edge_delay_ch.sv
// One edge delay channel: follows signal_in_i immediately or after a
// programmable number of cnt_step ticks, depending on the edge direction.
module edge_delay_ch
    import edge_delay_pkg::*;
#(
    parameter int         CNTR_NBITS = 5,
    parameter logic       DEF_OUTPUT = 1'b0,
    parameter logic [1:0] DELAY_MODE = DLY_RISE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cnt_step_i,
    input  logic [CNTR_NBITS-1:0] size_rise_i,
    input  logic [CNTR_NBITS-1:0] size_fall_i,
    input  logic                  signal_in_i,
    input  logic                  force_en_i,
    input  logic                  force_val_i,
    output logic                  delay_output_o,
    output logic                  edge_pulse_o,
    output logic                  busy_o
);

    ch_state_e             state_q, state_d;
    logic [CNTR_NBITS-1:0] timer_q, timer_d;
    logic [CNTR_NBITS-1:0] size;
    logic                  out_q, out_d;
    logic                  pulse_q;
    logic                  delayed;

    // The step seen on the edge that registers the divergence is not counted,
    // so the output follows on the (size+1)-th step seen while pending.
    always_comb begin
        size    = signal_in_i ? size_rise_i : size_fall_i;
        delayed = edge_is_delayed(DELAY_MODE, signal_in_i);
        state_d = state_q;
        timer_d = timer_q;
        out_d   = out_q;
        if (force_en_i) begin
            out_d   = force_val_i;
            timer_d = '0;
            state_d = ST_IDLE;
        end else if (signal_in_i == out_q) begin
            timer_d = '0;
            state_d = ST_IDLE;
        end else if (!delayed) begin
            out_d   = signal_in_i;
            timer_d = '0;
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            timer_d = '0;
            state_d = ST_PEND;
        end else if (cnt_step_i) begin
            if (timer_q == size) begin
                out_d   = signal_in_i;
                timer_d = '0;
                state_d = ST_IDLE;
            end else begin
                timer_d = timer_q + CNTR_NBITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            out_q   <= DEF_OUTPUT;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            out_q   <= out_d;
            pulse_q <= (out_d != out_q);
        end
    end

    assign delay_output_o = out_q;
    assign edge_pulse_o   = pulse_q;
    assign busy_o         = (state_q == ST_PEND);

endmodule

// File: rtl/edge_delay_mc.sv
// Multi-channel edge delay / debounce block. Defining EDGE_DELAY_MC_FORCE_EN
// adds per-channel force_en/force_val override ports.
module edge_delay_mc
    import edge_delay_pkg::*;
#(
    parameter int             NCH        = 4,
    parameter int             CNTR_NBITS = 5,
    parameter logic [NCH-1:0] DEF_OUTPUT = {NCH{1'b0}},
    parameter logic [1:0]     DELAY_MODE = DLY_RISE
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cnt_step,
    input  logic [NCH*CNTR_NBITS-1:0] cnt_size_rise,
    input  logic [NCH*CNTR_NBITS-1:0] cnt_size_fall,
    input  logic [NCH-1:0]            signal_in,
`ifdef EDGE_DELAY_MC_FORCE_EN
    input  logic [NCH-1:0]            force_en,
    input  logic [NCH-1:0]            force_val,
`endif
    output logic [NCH-1:0]            delay_output,
    output logic [NCH-1:0]            edge_pulse,
    output logic [NCH-1:0]            busy
);

    logic [NCH-1:0] forceEn;
    logic [NCH-1:0] forceVal;

`ifdef EDGE_DELAY_MC_FORCE_EN
    assign forceEn  = force_en;
    assign forceVal = force_val;
`else
    assign forceEn  = '0;
    assign forceVal = '0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        edge_delay_ch #(
            .CNTR_NBITS (CNTR_NBITS),
            .DEF_OUTPUT (DEF_OUTPUT[i]),
            .DELAY_MODE (DELAY_MODE)
        ) u_ch (
            .clk            (clk),
            .reset_n        (reset_n),
            .cnt_step_i     (cnt_step),
            .size_rise_i    (cnt_size_rise[i*CNTR_NBITS +: CNTR_NBITS]),
            .size_fall_i    (cnt_size_fall[i*CNTR_NBITS +: CNTR_NBITS]),
            .signal_in_i    (signal_in[i]),
            .force_en_i     (forceEn[i]),
            .force_val_i    (forceVal[i]),
            .delay_output_o (delay_output[i]),
            .edge_pulse_o   (edge_pulse[i]),
            .busy_o         (busy[i])
        );
    end

endmodule

// File: doc/edge_delay_mc.md
Name: edge_delay_mc

Overview:
- Multi-channel, parametrised successor to the single-edge delay cell.
- Each channel delays the rising edge, the falling edge, or both edges (debounce/filter mode), by independent per-channel, per-edge tick counts.
- Adds per-channel edge-event pulses and busy flags.
- Used in power-sequencing and board-signal conditioning, e.g. PG/reset-release delays and button/present-pin debounce, driven by the common timer tick.

Parameters:
- NCH, 4: number of independent channels.
- CNTR_NBITS, 5: width of each delay count and of each channel timer.
- DEF_OUTPUT, {NCH{1'b0}}: per-channel reset value of delay_output, one bit per channel.
- DELAY_MODE, 2'd0: edge selection applied to all channels. 0 = rise delayed; 1 = fall delayed; 2 = both delayed; 3 = reserved, treated as 2.

Ports:
- clk, input, 1: single clock.
- reset_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- cnt_step, input, 1: time increment, normally a one-cycle tick.
- cnt_size_rise, input, NCH*CNTR_NBITS: rising-edge delay. Channel i uses bits [i*CNTR_NBITS +: CNTR_NBITS].
- cnt_size_fall, input, NCH*CNTR_NBITS: falling-edge delay, same slicing.
- signal_in, input, NCH: input signals, assumed already synchronised to clk.
- delay_output, output, NCH: delayed or filtered outputs.
- edge_pulse, output, NCH: one-cycle pulse in the cycle after delay_output[i] changes.
- busy, output, NCH: high while channel i has a delayed edge pending.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - delay_output <= DEF_OUTPUT.
  - All timers <= 0.
  - edge_pulse <= 0 and busy <= 0.
  - Reset overrides every other condition, including mid-count; any pending edge is discarded.
- Per channel, two states: IDLE (signal_in[i]==delay_output[i]) and PEND (they differ, and the edge is delayed).
  - busy[i] = (state==PEND), combinational from registered state.
- Non-delayed edge (mode excludes it):
  - delay_output[i] <= signal_in[i] on the next clk edge (1-cycle latency).
  - Timer is cleared; no PEND entry.
- Delayed edge:
  - Select size = cnt_size_rise if signal_in[i]==1, else cnt_size_fall.
  - In PEND, on each cycle with cnt_step=1:
    - If timer==size: delay_output[i] <= signal_in[i], timer <= 0, go to IDLE.
    - Otherwise timer <= timer+1.
  - Cycles without cnt_step hold the timer.
  - Net result: the output follows on the (size+1)-th cnt_step after the divergence is first registered. size=0 means the first step.
- Abort: if signal_in[i] returns to delay_output[i] while in PEND, the timer clears to 0 next cycle and the state returns to IDLE. The output never changes. In mode 2 this is the debounce behaviour.
- Size change mid-count: the new size takes effect immediately. If the timer already exceeds the new size, it keeps incrementing, wraps modulo 2^CNTR_NBITS and fires on reaching the size. Firmware must not change sizes while busy.
- Timer arithmetic: unsigned, CNTR_NBITS wide. It never exceeds size except in the mid-count-change case above.
- edge_pulse[i]: registered as (delay_output_next[i] != delay_output[i]). It is therefore high in the cycle after the change, and is suppressed in the cycle that reset is released.
- Channels are fully independent; simultaneous events on different channels have no interaction.

Optional Feature:
- Macro: EDGE_DELAY_MC_FORCE_EN.
- When defined:
  - Adds ports force_en [NCH] and force_val [NCH].
  - While force_en[i]=1: delay_output[i] <= force_val[i] each cycle, timer held at 0, busy[i]=0. edge_pulse still reports changes.
  - On release, normal evaluation resumes from the forced value. Any divergence from signal_in[i] starts a fresh delay, or an immediate follow if that edge is not delayed.
  - Reset has priority over force.
- When not defined: the ports are absent and the logic is identical to the unforced path.

Decomposition:
- Package edge_delay_pkg:
  - Mode constants DLY_RISE=2'd0, DLY_FALL=2'd1, DLY_BOTH=2'd2.
  - Channel state encoding ST_IDLE/ST_PEND.
  - Helper function edge_is_delayed(mode, target_level).
- Sub-module edge_delay_ch: one channel, instantiated NCH times by a generate loop. The top level handles only slicing of the size buses and the optional force ports.

Test Plan:
- Mode 0, size_rise=3, cnt_step every 4 clks, signal_in[0] 0->1 -> delay_output[0] rises on the 4th step, busy high throughout, edge_pulse one cycle. Then 1->0 -> output falls 1 clk later with no busy.
- Mode 2, rise=2, fall=5, cnt_step every clk:
  - Input high for 2 clks then low -> output stays 0, busy drops, timer cleared.
  - Input high for 4 clks -> output rises at step 3.
  - Then low -> output falls at step 6.
- Channels 0..3 driven simultaneously with sizes 0, 1, 7, 31 (CNTR_NBITS=5) -> outputs follow at steps 1, 2, 8, 32 independently. Size 31 completes without overflow.
- reset_n asserted mid-count, timer=2 of 5, DEF_OUTPUT=4'b1010 -> next edge outputs = 1010, busy=0, no edge_pulse. After release, a fresh full delay is applied.
- cnt_step held 0 for 20 clks mid-PEND -> timer frozen and output unchanged. Counting resumes from the held value.
- With EDGE_DELAY_MC_FORCE_EN: force_en[1]=1 and force_val=1 during a pending fall -> output 1 and busy 0. Release with input 0 -> a full fall delay restarts.
